// File: rtl/multicycle_controller_fsm_decoder_if.sv
// Controller <-> datapath bundle: instruction/memory handshake in, state and datapath controls out.
// master = controller side, slave = datapath (or bench) side.
interface multicycle_controller_fsm_decoder_if #(
    parameter int INSTR_W = 32,
    parameter int SHIFT_W = 3
);
    logic [INSTR_W-1:0] INSTRUCTION;
    logic               MemReady;
    logic               CondEx;
    logic [3:0]         State;
    logic               PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA;
    logic [1:0]         ALUSrcB, ResultSrc, ALUControl, FlagW, RegSrc, ImmSrc;
    logic [SHIFT_W-1:0] ShiftType;
    logic               Illegal;

    modport master (
        input  INSTRUCTION, MemReady, CondEx,
        output State, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA,
               ALUSrcB, ResultSrc, ALUControl, FlagW, RegSrc, ImmSrc, ShiftType, Illegal
    );

    modport slave (
        output INSTRUCTION, MemReady, CondEx,
        input  State, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA,
               ALUSrcB, ResultSrc, ALUControl, FlagW, RegSrc, ImmSrc, ShiftType, Illegal
    );
endinterface

// File: rtl/multicycle_controller_fsm_decoder.sv
// Multicycle ARM-subset controller: main FSM plus instruction decoder driving datapath selects.
// Optional MC_CTRL_BX_EN adds the BX (branch-exchange) state.
module multicycle_controller_fsm_decoder #(
    parameter int INSTR_W   = 32,
    parameter int SHIFT_LSB = 4,
    parameter int SHIFT_W   = 3
) (
    input logic CLK,
    input logic RESET,
    multicycle_controller_fsm_decoder_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
        S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
        S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_BX = 4'd10
    } state_t;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    state_t state, next_state;

    logic [1:0]         op_q;
    logic               i_q;
    logic [3:0]         cmd_q;
    logic               s_q;   // bit 20: S for data-processing, L for memory
    logic [SHIFT_W-1:0] shift_q;

    logic [1:0]         in_op;
    logic               in_i;
    logic [3:0]         in_cmd;
    logic [SHIFT_W-1:0] in_shift;
    logic               bx_hit;
    logic               illegal_dec;
    logic               early;
    logic [1:0]         src_op;
    logic               unused_ok;

    function automatic logic cmd_ok(input logic [3:0] c);
        return (c == CMD_ADD) || (c == CMD_SUB) || (c == CMD_AND) ||
               (c == CMD_ORR) || (c == CMD_CMP);
    endfunction

    function automatic logic [1:0] alu_sel(input logic [3:0] c);
        case (c)
            CMD_SUB, CMD_CMP: return 2'b01;
            CMD_AND:          return 2'b10;
            CMD_ORR:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    assign in_op    = bus.INSTRUCTION[27:26];
    assign in_i     = bus.INSTRUCTION[25];
    assign in_cmd   = bus.INSTRUCTION[24:21];
    assign in_shift = bus.INSTRUCTION[SHIFT_LSB+SHIFT_W-1:SHIFT_LSB];

`ifdef MC_CTRL_BX_EN
    assign bx_hit = (bus.INSTRUCTION[27:4] == 24'h12FFF1);
`else
    assign bx_hit = 1'b0;
`endif

    // Undecodable is a property of the word itself, independent of CondEx.
    assign illegal_dec = !bx_hit &&
                         ((in_op == 2'b11) || ((in_op == 2'b00) && !cmd_ok(in_cmd)));

    // Upper instruction bits and I are carried but not needed past decode.
    assign unused_ok = ^{bus.INSTRUCTION, i_q};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_FETCH;
            op_q    <= '0;
            i_q     <= 1'b0;
            cmd_q   <= '0;
            s_q     <= 1'b0;
            shift_q <= '0;
        end else begin
            state <= next_state;
            if (state == S_DECODE) begin
                op_q    <= in_op;
                i_q     <= in_i;
                cmd_q   <= in_cmd;
                s_q     <= bus.INSTRUCTION[20];
                shift_q <= in_shift;
            end
        end
    end

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = bus.MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                if (!bus.CondEx || illegal_dec) next_state = S_FETCH;
                else if (bx_hit)                next_state = S_BX;
                else begin
                    case (in_op)
                        2'b00:   next_state = in_i ? S_EXECI : S_EXECR;
                        2'b01:   next_state = S_MEMADR;
                        2'b10:   next_state = S_BRANCH;
                        default: next_state = S_FETCH;
                    endcase
                end
            end
            S_EXECR, S_EXECI: next_state = (cmd_q == CMD_CMP) ? S_FETCH : S_ALUWB;
            S_MEMADR:   next_state = s_q ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  next_state = bus.MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: next_state = bus.MemReady ? S_FETCH : S_MEMWRITE;
            default:    next_state = S_FETCH;
        endcase
    end

    assign early  = (state == S_FETCH) || (state == S_DECODE);
    assign src_op = early ? in_op : op_q;

    always_comb begin
        bus.State      = state;
        bus.PCWrite    = 1'b0;
        bus.IRWrite    = 1'b0;
        bus.AdrSrc     = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.RegWrite   = 1'b0;
        bus.ALUSrcA    = 1'b0;
        bus.ALUSrcB    = 2'b00;
        bus.ResultSrc  = 2'b00;
        bus.ALUControl = 2'b00;
        bus.FlagW      = 2'b00;
        bus.RegSrc     = 2'b00;
        bus.ImmSrc     = 2'b00;
        bus.ShiftType  = early ? in_shift : shift_q;
        bus.Illegal    = 1'b0;

        case (src_op)
            2'b01: begin bus.RegSrc = 2'b10; bus.ImmSrc = 2'b01; end
            2'b10: begin bus.RegSrc = 2'b01; bus.ImmSrc = 2'b10; end
            default: ;
        endcase

        case (state)
            S_FETCH: begin
                bus.IRWrite   = 1'b1;
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = 2'b10;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = bus.MemReady;
            end
            S_DECODE:   bus.Illegal = illegal_dec;
            S_MEMADR:   bus.ALUSrcB = 2'b01;
            S_MEMREAD:  bus.AdrSrc  = 1'b1;
            S_MEMWB: begin
                bus.ResultSrc = 2'b01;
                bus.RegWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                bus.AdrSrc   = 1'b1;
                bus.MemWrite = 1'b1;
            end
            S_EXECR, S_EXECI: begin
                bus.ALUSrcB    = (state == S_EXECI) ? 2'b01 : 2'b00;
                bus.ALUControl = alu_sel(cmd_q);
                if (cmd_q == CMD_CMP)
                    bus.FlagW = 2'b11;
                else if (s_q && ((cmd_q == CMD_ADD) || (cmd_q == CMD_SUB)))
                    bus.FlagW = 2'b11;
                else if (s_q && ((cmd_q == CMD_AND) || (cmd_q == CMD_ORR)))
                    bus.FlagW = 2'b10;
            end
            S_ALUWB:    bus.RegWrite = 1'b1;
            S_BRANCH: begin
                bus.ALUSrcB   = 2'b01;
                bus.ResultSrc = 2'b10;
                bus.PCWrite   = 1'b1;
            end
`ifdef MC_CTRL_BX_EN
            S_BX: begin
                bus.ResultSrc = 2'b11;
                bus.PCWrite   = 1'b1;
            end
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller_fsm_decoder.sv
// Scoreboard bench: driver pushes per-cycle expectations from an instruction-level model,
// monitor pops and compares against the DUT outputs.
module tb_multicycle_controller_fsm_decoder;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    multicycle_controller_fsm_decoder_if #(.INSTR_W(32), .SHIFT_W(3)) bus ();

    multicycle_controller_fsm_decoder #(.INSTR_W(32), .SHIFT_LSB(4), .SHIFT_W(3)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    localparam logic [31:0] I_ADD  = 32'hE0910002;
    localparam logic [31:0] I_LDR  = 32'hE5912004;
    localparam logic [31:0] I_STR  = 32'hE5812004;
    localparam logic [31:0] I_OP11 = 32'hEC000000;
    localparam logic [31:0] I_B    = 32'hEA000004;
    localparam logic [31:0] I_BX   = 32'hE12FFF11;
    localparam logic [31:0] I_CMP  = 32'hE1510002;
    localparam logic [31:0] I_SUBI = 32'hE2411001;
    localparam logic [31:0] I_AND  = 32'hE0012003;
    localparam logic [31:0] I_ORRS = 32'hE1912003;
    localparam logic [31:0] I_MOV  = 32'hE1A00000;

    logic [31:0] pool [11] = '{I_ADD, I_LDR, I_STR, I_OP11, I_B, I_BX, I_CMP, I_SUBI,
                               I_AND, I_ORRS, I_MOV};

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [25:0] exp_q[$];

    // Instruction-level model: current state code plus the remaining planned states.
    int mst = 0;
    int path[$];
    bit known = 0;
    logic [1:0] m_op = '0;
    logic [3:0] m_cmd = '0;
    logic       m_s = 1'b0;
    logic [2:0] m_sh = '0;

    function automatic bit supported(input logic [3:0] c);
        return c == 4'b0100 || c == 4'b0010 || c == 4'b0000 || c == 4'b1100 || c == 4'b1010;
    endfunction

    function automatic bit is_bx(input logic [31:0] ins);
`ifdef MC_CTRL_BX_EN
        return ins[27:4] == 24'h12FFF1;
`else
        return ins[31] & 1'b0;
`endif
    endfunction

    function automatic bit undecodable(input logic [31:0] ins);
        if (is_bx(ins)) return 1'b0;
        if (ins[27:26] == 2'b11) return 1'b1;
        return ins[27:26] == 2'b00 && !supported(ins[24:21]);
    endfunction

    function automatic logic [21:0] expect_out(input int st, input logic [31:0] ins, input logic mr);
        logic pcw = 0, irw = 0, adr = 0, mw = 0, rw = 0, asa = 0, ill = 0;
        logic [1:0] asb = 0, rs = 0, alu = 0, fw = 0, rsrc = 0, isrc = 0, opv;
        logic [2:0] sh;
        opv = (st <= 1) ? ins[27:26] : m_op;
        sh  = (st <= 1) ? ins[6:4] : m_sh;
        if (opv == 2'b01) begin rsrc = 2'b10; isrc = 2'b01; end
        if (opv == 2'b10) begin rsrc = 2'b01; isrc = 2'b10; end
        case (st)
            0: begin irw = 1; asa = 1; asb = 2'b10; rs = 2'b10; pcw = mr; end
            1: ill = undecodable(ins);
            2: asb = 2'b01;
            3: adr = 1;
            4: begin rs = 2'b01; rw = 1; end
            5: begin adr = 1; mw = 1; end
            6, 7: begin
                asb = (st == 7) ? 2'b01 : 2'b00;
                case (m_cmd)
                    4'b0010, 4'b1010: alu = 2'b01;
                    4'b0000: alu = 2'b10;
                    4'b1100: alu = 2'b11;
                    default: alu = 2'b00;
                endcase
                if (m_cmd == 4'b1010) fw = 2'b11;
                else if (m_s && (m_cmd == 4'b0100 || m_cmd == 4'b0010)) fw = 2'b11;
                else if (m_s && (m_cmd == 4'b0000 || m_cmd == 4'b1100)) fw = 2'b10;
            end
            8: rw = 1;
            9: begin asb = 2'b01; rs = 2'b10; pcw = 1; end
            10: begin rs = 2'b11; pcw = 1; end
            default: ;
        endcase
        return {pcw, irw, adr, mw, rw, asa, asb, rs, alu, fw, rsrc, isrc, sh, ill};
    endfunction

    task automatic advance();
        mst = (path.size() > 0) ? path.pop_front() : 0;
    endtask

    task automatic model_step(input logic [31:0] ins, input logic mr, input logic ce, input logic rst);
        if (rst) begin
            mst = 0; path.delete();
            m_op = '0; m_cmd = '0; m_s = 1'b0; m_sh = '0;
            return;
        end
        case (mst)
            0: if (mr) mst = 1;
            1: begin
                m_op = ins[27:26]; m_cmd = ins[24:21]; m_s = ins[20]; m_sh = ins[6:4];
                path.delete();
                if (ce && !undecodable(ins)) begin
                    if (is_bx(ins)) path.push_back(10);
                    else if (ins[27:26] == 2'b00) begin
                        path.push_back(ins[25] ? 7 : 6);
                        if (ins[24:21] != 4'b1010) path.push_back(8);
                    end else if (ins[27:26] == 2'b01) begin
                        path.push_back(2);
                        if (ins[20]) begin path.push_back(3); path.push_back(4); end
                        else path.push_back(5);
                    end else path.push_back(9);
                end
                advance();
            end
            3, 5: if (mr) advance();
            default: advance();
        endcase
    endtask

    task automatic cycle(input logic [31:0] ins, input logic mr, input logic ce, input logic rst);
        @(negedge CLK);
        bus.INSTRUCTION = ins;
        bus.MemReady    = mr;
        bus.CondEx      = ce;
        RESET           = rst;
        if (known) exp_q.push_back({4'(mst), expect_out(mst, ins, mr)});
        model_step(ins, mr, ce, rst);
        if (rst) known = 1;
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic ce, input int waits);
        int w = waits;
        int n = 0;
        logic mr;
        do begin
            mr = ((mst == 3 || mst == 5) && w > 0) ? 1'b0 : 1'b1;
            if (!mr) w--;
            cycle(ins, mr, ce, 1'b0);
            n++;
        end while (mst != 0 && n < 20);
        if (n >= 20) begin
            checks++; failures++;
            $display("FAIL run_bound ins=%h got=%0d cycles required<20", ins, n);
        end
    endtask

    initial begin : monitor
        logic [25:0] e;
        logic [21:0] got;
        forever begin
            @(negedge CLK);
            #3;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {bus.PCWrite, bus.IRWrite, bus.AdrSrc, bus.MemWrite, bus.RegWrite,
                       bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl, bus.FlagW,
                       bus.RegSrc, bus.ImmSrc, bus.ShiftType, bus.Illegal};
                checks++;
                if (bus.State !== e[25:22]) begin
                    failures++;
                    $display("FAIL state cyc=%0d got=%0d exp=%0d", cyc, bus.State, e[25:22]);
                end
                checks++;
                if (got !== e[21:0]) begin
                    failures++;
                    $display("FAIL outputs cyc=%0d state=%0d got=%h exp=%h", cyc, e[25:22], got, e[21:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [31:0] cur;
        bus.INSTRUCTION = '0;
        bus.MemReady    = 1'b0;
        bus.CondEx      = 1'b0;
        cycle(I_ADD, 1'b0, 1'b1, 1'b1);
        cycle(I_ADD, 1'b1, 1'b1, 1'b1);   // outputs while held in reset
        cycle(I_ADD, 1'b0, 1'b1, 1'b0);

        // Reset arriving mid-wait in MEMREAD
        cycle(I_LDR, 1'b1, 1'b1, 1'b0);
        cycle(I_LDR, 1'b1, 1'b1, 1'b0);
        cycle(I_LDR, 1'b1, 1'b1, 1'b0);
        cycle(I_LDR, 1'b0, 1'b1, 1'b0);
        cycle(I_LDR, 1'b0, 1'b1, 1'b1);
        cycle(I_LDR, 1'b0, 1'b1, 1'b0);

        run_instr(I_ADD, 1'b1, 0);
        run_instr(I_LDR, 1'b1, 3);
        run_instr(I_OP11, 1'b1, 0);
        run_instr(I_B, 1'b0, 0);
        run_instr(I_B, 1'b1, 0);
        run_instr(I_BX, 1'b1, 0);
        run_instr(I_STR, 1'b1, 2);
        run_instr(I_CMP, 1'b1, 0);
        run_instr(I_SUBI, 1'b1, 0);
        run_instr(I_AND, 1'b1, 0);
        run_instr(I_ORRS, 1'b1, 0);
        run_instr(I_MOV, 1'b1, 0);

        cur = I_ADD;
        for (int k = 0; k < 2000; k++) begin
            if (mst == 0)
                cur = ($urandom_range(0, 3) == 0) ? 32'($urandom) : pool[$urandom_range(0, 10)];
            cycle(cur, $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 59) == 0);
        end

        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
